// File: rtl/formateador_dac.sv
// Formats a round-robin multichannel two's-complement sample stream into DAC codes:
// optional round-half-up, right shift, saturate or wrap, and offset-binary conversion.
module formateador_dac #(
    parameter int W_IN  = 16,
    parameter int W_OUT = 12,
    parameter int N_CH  = 2,
    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_IN-1:0]   Dato_In,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        Desp,
    input  logic              Modo_Redondeo,
    input  logic              Modo_Sat,
    input  logic              Modo_Offset,
    output logic [W_OUT-1:0]  Dato_Out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     Canal_Out,
    output logic              Frame_Fin,
    output logic              Sat_Flag,
    output logic [7:0]        Cnt_Sat
);
    localparam int         MAXD  = W_IN - W_OUT;
    localparam logic [2:0] MAXD3 = 3'((MAXD > 7) ? 7 : MAXD);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high.
    // The whole pipeline moves together whenever the output register is empty or being
    // drained, so in_ready is exactly that advance condition.
    logic advance, in_fire, out_fire;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign in_fire  = in_valid && advance;
    assign out_fire = out_valid && out_ready;

    logic            s1_valid_q, s1_rnd_q, s1_sat_q, s1_off_q;
    logic [W_IN-1:0] s1_data_q;
    logic [2:0]      s1_desp_q;
    logic [CW-1:0]   s1_ch_q;

    logic            s2_valid_q, s2_sat_q, s2_off_q;
    logic [W_IN:0]   s2_xr_q;
    logic [2:0]      s2_desp_q;
    logic [CW-1:0]   s2_ch_q;

    logic [W_OUT-1:0] dato_q;
    logic             out_valid_q, frame_q, flag_q;
    logic [CW-1:0]    canal_q, ch_q;
    logic [7:0]       cnt_q;

    logic [2:0]         desp_d;
    logic [W_IN:0]      rnd_d, xr_d;
    logic signed [W_IN:0] y_d;
    logic               ovf_d, frame_d;
    logic [W_OUT-1:0]   code_d;
    logic [CW-1:0]      ch_d;
    logic [7:0]         cnt_d;

    assign desp_d = (Desp > MAXD3) ? MAXD3 : Desp;

    always_comb begin
        rnd_d = '0;
        if (s1_rnd_q && s1_desp_q != 3'd0)
            rnd_d = (W_IN+1)'(1) << (s1_desp_q - 3'd1);
        xr_d = {s1_data_q[W_IN-1], s1_data_q} + rnd_d;
    end

    // Out of range exactly when the bits above the output sign bit disagree with it.
    always_comb begin
        y_d   = $signed(s2_xr_q) >>> s2_desp_q;
        ovf_d = !(&y_d[W_IN:W_OUT-1]) && (|y_d[W_IN:W_OUT-1]);
        if (ovf_d && s2_sat_q)
            code_d = y_d[W_IN] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
        else
            code_d = y_d[W_OUT-1:0];
        if (s2_off_q)
            code_d[W_OUT-1] = ~code_d[W_OUT-1];
    end

    always_comb begin
        ch_d = ch_q;
        if (in_fire)
            ch_d = (ch_q == CW'(N_CH-1)) ? '0 : ch_q + CW'(1);
        cnt_d = cnt_q;
        if (out_fire && flag_q && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
        frame_d = (s2_ch_q == CW'(N_CH-1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0; s1_rnd_q <= 1'b0; s1_sat_q <= 1'b0; s1_off_q <= 1'b0;
            s1_data_q <= '0; s1_desp_q <= '0; s1_ch_q <= '0;
            s2_valid_q <= 1'b0; s2_sat_q <= 1'b0; s2_off_q <= 1'b0;
            s2_xr_q <= '0; s2_desp_q <= '0; s2_ch_q <= '0;
            out_valid_q <= 1'b0; dato_q <= '0; canal_q <= '0; frame_q <= 1'b0;
            flag_q <= 1'b0; cnt_q <= '0; ch_q <= '0;
        end else begin
            ch_q  <= ch_d;
            cnt_q <= cnt_d;
            if (advance) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= Dato_In;
                    s1_desp_q <= desp_d;
                    s1_rnd_q  <= Modo_Redondeo;
                    s1_sat_q  <= Modo_Sat;
                    s1_off_q  <= Modo_Offset;
                    s1_ch_q   <= ch_q;
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_xr_q   <= xr_d;
                    s2_desp_q <= s1_desp_q;
                    s2_sat_q  <= s1_sat_q;
                    s2_off_q  <= s1_off_q;
                    s2_ch_q   <= s1_ch_q;
                end
                out_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    dato_q  <= code_d;
                    flag_q  <= ovf_d;
                    canal_q <= s2_ch_q;
                    frame_q <= frame_d;
                end
            end
        end
    end

    assign Dato_Out  = dato_q;
    assign out_valid = out_valid_q;
    assign Canal_Out = canal_q;
    assign Frame_Fin = frame_q;
    assign Sat_Flag  = flag_q;
    assign Cnt_Sat   = cnt_q;
endmodule

// File: tb/tb_formateador_dac.sv
// Bench for formateador_dac: directed vector table, stall/reset sequences, and a
// randomized run scored against an arithmetic model of the formatting rules.
module tb_formateador_dac;
    localparam int W_IN  = 16;
    localparam int W_OUT = 12;
    localparam int N_CH  = 2;
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int EW    = W_OUT + 1 + CW;
    localparam int MAXD  = W_IN - W_OUT;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [W_IN-1:0]  Dato_In = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       Desp = '0;
    logic             Modo_Redondeo = 1'b0, Modo_Sat = 1'b0, Modo_Offset = 1'b0;
    logic [W_OUT-1:0] Dato_Out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CW-1:0]    Canal_Out;
    logic             Frame_Fin, Sat_Flag;
    logic [7:0]       Cnt_Sat;

    formateador_dac #(.W_IN(W_IN), .W_OUT(W_OUT), .N_CH(N_CH)) dut (
        .clk(clk), .reset(reset), .Dato_In(Dato_In), .in_valid(in_valid),
        .in_ready(in_ready), .Desp(Desp), .Modo_Redondeo(Modo_Redondeo),
        .Modo_Sat(Modo_Sat), .Modo_Offset(Modo_Offset), .Dato_Out(Dato_Out),
        .out_valid(out_valid), .out_ready(out_ready), .Canal_Out(Canal_Out),
        .Frame_Fin(Frame_Fin), .Sat_Flag(Sat_Flag), .Cnt_Sat(Cnt_Sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    int m_ch  = 0;
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the signed sample value.
    function automatic logic [EW-1:0] model(input logic [W_IN-1:0] din, input logic [2:0] d,
                                            input logic r, input logic s, input logic o,
                                            input int ch);
        int sh, v, y, lo, hi, code;
        logic flag;
        sh = (d > MAXD) ? MAXD : int'(d);
        v  = int'($signed(din));
        if (r && sh > 0) v = v + (1 << (sh - 1));
        y  = v >>> sh;
        lo = -(1 << (W_OUT - 1));
        hi = (1 << (W_OUT - 1)) - 1;
        flag = (y < lo) || (y > hi);
        code = (flag && s) ? ((y < lo) ? lo : hi) : y;
        code = code & ((1 << W_OUT) - 1);
        if (o) code = code ^ (1 << (W_OUT - 1));
        return {CW'(ch), flag, W_OUT'(code)};
    endfunction

    logic [EW-1:0] e_mon;
    always @(negedge clk) begin
        if (!reset) begin
            chk("cnt_sat", Cnt_Sat, m_cnt);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got output 0x%0h expected none at %0t", Dato_Out, $time);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("sb_code", Dato_Out, e_mon[W_OUT-1:0]);
                    chk("sb_flag", Sat_Flag, e_mon[W_OUT]);
                    chk("sb_chan", Canal_Out, e_mon[EW-1:W_OUT+1]);
                    chk("sb_frame", Frame_Fin, (int'(e_mon[EW-1:W_OUT+1]) == N_CH - 1));
                    if (e_mon[W_OUT] && m_cnt < 255) m_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(Dato_In, Desp, Modo_Redondeo, Modo_Sat, Modo_Offset, m_ch));
                m_ch = (m_ch + 1) % N_CH;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        m_ch  = 0;
        m_cnt = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dato", Dato_Out, 0);
        chk("rst_canal", Canal_Out, 0);
        chk("rst_frame", Frame_Fin, 0);
        chk("rst_flag", Sat_Flag, 0);
        chk("rst_cnt", Cnt_Sat, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic rand_in();
        Dato_In       = W_IN'($urandom);
        Desp          = 3'($urandom_range(0, 7));
        Modo_Redondeo = 1'($urandom_range(0, 1));
        Modo_Sat      = 1'($urandom_range(0, 1));
        Modo_Offset   = 1'($urandom_range(0, 1));
    endtask

    typedef struct {
        logic [W_IN-1:0]  din;
        logic [2:0]       d;
        logic             r, s, o;
        logic [W_OUT-1:0] code;
        logic             flag;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{16'h1237, 3'd4, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0};
        tbl[1]  = '{16'h1238, 3'd4, 1'b1, 1'b0, 1'b0, 12'h124, 1'b0};
        tbl[2]  = '{16'h1237, 3'd4, 1'b1, 1'b0, 1'b0, 12'h123, 1'b0};
        tbl[3]  = '{16'h8000, 3'd4, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0};
        tbl[4]  = '{16'h7FF0, 3'd4, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b0};
        tbl[5]  = '{16'h0000, 3'd4, 1'b0, 1'b0, 1'b1, 12'h800, 1'b0};
        tbl[6]  = '{16'h1000, 3'd0, 1'b0, 1'b1, 1'b0, 12'h7FF, 1'b1};
        tbl[7]  = '{16'h1000, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1};
        tbl[8]  = '{16'h7FF8, 3'd4, 1'b1, 1'b1, 1'b0, 12'h7FF, 1'b1};
        tbl[9]  = '{16'h1237, 3'd7, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0};
        tbl[10] = '{16'h8000, 3'd0, 1'b0, 1'b1, 1'b0, 12'h800, 1'b1};

        do_reset();

        // Directed vectors with exact two-edge latency.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            Dato_In = tbl[i].din; Desp = tbl[i].d;
            Modo_Redondeo = tbl[i].r; Modo_Sat = tbl[i].s; Modo_Offset = tbl[i].o;
            step();
            in_valid = 1'b0;
            Desp = 3'd0; Modo_Redondeo = 1'b0; Modo_Sat = 1'b0; Modo_Offset = ~tbl[i].o;
            chk("lat_k0", out_valid, 0);
            step();
            chk("lat_k1", out_valid, 0);
            step();
            chk("vec_valid", out_valid, 1);
            chk("vec_code", Dato_Out, tbl[i].code);
            chk("vec_flag", Sat_Flag, tbl[i].flag);
            chk("vec_chan", Canal_Out, i % N_CH);
        end
        drain();

        // Backpressure: three stalled cycles with continuous input.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin rand_in(); step(); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [EW-1:0] front;
            rand_in();
            step();
            front = exp_q[0];
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_hold_code", Dato_Out, front[W_OUT-1:0]);
            chk("stall_hold_chan", Canal_Out, front[EW-1:W_OUT+1]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin rand_in(); step(); end
        drain();

        // Reset with samples in flight.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        Dato_In = 16'h0100; Desp = 3'd0; Modo_Redondeo = 1'b0; Modo_Sat = 1'b0; Modo_Offset = 1'b0;
        step();
        Dato_In = 16'h0200;
        step();
        in_valid = 1'b0;
        step();
        do_reset();
        for (int i = 0; i < 3; i++) begin step(); chk("no_stale", out_valid, 0); end
        in_valid = 1'b1; Dato_In = 16'h1237; Desp = 3'd4;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_chan", Canal_Out, 0);
        chk("post_rst_code", Dato_Out, 12'h123);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_in();
            step();
        end
        drain();

        // Saturating event counter.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        Dato_In = 16'h1000; Desp = 3'd0; Modo_Redondeo = 1'b0; Modo_Sat = 1'b1; Modo_Offset = 1'b0;
        for (int i = 0; i < 300; i++) step();
        drain();
        chk("cnt_sat_hold", Cnt_Sat, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
